// File: rtl/ir_pkg.sv
// Shared types and helpers for the IR packet receive path.
// States, direction bit indices and the burst length matcher.
package ir_pkg;

  localparam int CNT_W = 8;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_BACK  = 2;
  localparam int BIT_FWD   = 3;

  typedef enum logic [2:0] {
    WAIT_START,
    WAIT_SEL,
    RIGHT,
    LEFT,
    BACK,
    FWD
  } state_t;

  function automatic logic match(
    input int n,
    input int l,
    input int tol
  );
    int d;
    d = (n > l) ? n - l : l - n;
    return d <= tol;
  endfunction

endpackage

// File: rtl/ir_burst_meter.sv
// Measures carrier bursts on the raw IR input in pulses, and
// times the silence between bursts.
module ir_burst_meter
  import ir_pkg::*;
#(
  parameter int ENV_TIMEOUT = 2500,
  parameter int GAP_MAX     = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_in,
  output logic             burst_done,
  output logic [CNT_W-1:0] n,
  output logic             gap_expired
);

  localparam int EW = $clog2(ENV_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_MAX + 3);

  logic [2:0]       sync;
  logic             pulse;
  logic             active;
  logic             gap_run;
  logic [EW-1:0]    env;
  logic [GW-1:0]    gap;
  logic [CNT_W-1:0] cnt;

  assign pulse       = sync[1] & ~sync[2];
  assign burst_done  = active && (env == EW'(ENV_TIMEOUT));
  assign n           = cnt;
  // gap counts the done cycle as 1; saturates one past the trip point
  assign gap_expired = gap_run && (gap == GW'(GAP_MAX + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      active  <= 1'b0;
      gap_run <= 1'b0;
      env     <= '0;
      gap     <= '0;
      cnt     <= '0;
    end else begin
      sync   <= {sync[1:0], ir_in};
      active <= pulse | (active & ~burst_done);

      if (pulse)
        env <= '0;
      else if (active && env != EW'(ENV_TIMEOUT))
        env <= env + EW'(1);

      if (burst_done)
        cnt <= pulse ? CNT_W'(1) : '0;
      else if (pulse && cnt != '1)
        cnt <= cnt + CNT_W'(1);

      if (pulse)
        gap_run <= 1'b0;
      else if (burst_done)
        gap_run <= 1'b1;

      if (burst_done)
        gap <= GW'(1);
      else if (gap_run && gap != GW'(GAP_MAX + 2))
        gap <= gap + GW'(1);
    end
  end

endmodule

// File: rtl/ir_packet_decoder.sv
// Decodes one IR remote packet (start, select, R/L/B/F bursts)
// into direction bits, with link-hold timeout.
module ir_packet_decoder
  import ir_pkg::*;
#(
  parameter int ENV_TIMEOUT  = 2500,
  parameter int GAP_MAX      = 100000,
  parameter int HOLD_CYCLES  = 10000000,
  parameter int START_LEN    = 191,
  parameter int SEL_LEN      = 47,
  parameter int ASSERT_LEN   = 47,
  parameter int DEASSERT_LEN = 22,
  parameter int TOL          = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IR_IN,
  output logic [3:0] DIR,
  output logic       PKT_VALID,
  output logic       PKT_ERR,
  output logic       LINK_OK
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic             burst_done;
  logic             gap_expired;
  logic [CNT_W-1:0] n;

  ir_burst_meter #(
    .ENV_TIMEOUT (ENV_TIMEOUT),
    .GAP_MAX     (GAP_MAX)
  ) u_meter (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .ir_in       (IR_IN),
    .burst_done  (burst_done),
    .n           (n),
    .gap_expired (gap_expired)
  );

  state_t        state, state_n, nxt;
  logic [3:0]    bits, bits_n;
  logic [1:0]    idx;
  logic          valid_n, err_n;
  logic          m_start, m_sel, m_one, m_zero;
  logic [HW-1:0] hold;
  logic          expire;

  assign m_start = match(int'(n), START_LEN, TOL);
  assign m_sel   = match(int'(n), SEL_LEN, TOL);
  assign m_one   = match(int'(n), ASSERT_LEN, TOL);
  assign m_zero  = match(int'(n), DEASSERT_LEN, TOL);
  assign expire  = LINK_OK && (hold == '0);

  always_comb begin
    idx = 2'(BIT_RIGHT);
    nxt = WAIT_START;
    unique case (state)
      RIGHT: begin idx = 2'(BIT_RIGHT); nxt = LEFT; end
      LEFT:  begin idx = 2'(BIT_LEFT);  nxt = BACK; end
      BACK:  begin idx = 2'(BIT_BACK);  nxt = FWD;  end
      FWD:   begin idx = 2'(BIT_FWD);   nxt = WAIT_START; end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    bits_n  = bits;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (gap_expired && state != WAIT_START) begin
      err_n   = 1'b1;
      bits_n  = '0;
      state_n = WAIT_START;
    end else if (burst_done) begin
      unique case (state)
        WAIT_START: begin
          if (m_start) state_n = WAIT_SEL;
        end
        WAIT_SEL: begin
          if (m_sel) begin
            state_n = RIGHT;
          end else if (!m_start) begin
            err_n   = 1'b1;
            state_n = WAIT_START;
          end
        end
        default: begin
          unique case (1'b1)
            m_one, m_zero: begin
              bits_n[idx] = m_one;
              state_n     = nxt;
              valid_n     = (state == FWD);
            end
            m_start: begin
              err_n   = 1'b1;
              bits_n  = '0;
              state_n = WAIT_SEL;
            end
            default: begin
              err_n   = 1'b1;
              bits_n  = '0;
              state_n = WAIT_START;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= WAIT_START;
      bits      <= '0;
      DIR       <= '0;
      PKT_VALID <= 1'b0;
      PKT_ERR   <= 1'b0;
      LINK_OK   <= 1'b0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      bits      <= bits_n;
      PKT_VALID <= valid_n;
      PKT_ERR   <= err_n;
      // a fresh packet beats a simultaneous hold expiry
      if (valid_n) begin
        DIR     <= bits_n;
        LINK_OK <= 1'b1;
        hold    <= HW'(HOLD_CYCLES - 1);
      end else if (expire) begin
        DIR     <= '0;
        LINK_OK <= 1'b0;
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed bench for ir_packet_decoder with an event scoreboard.
// Expected strobes are queued at stimulus time, checked on output.
module tb_ir_packet_decoder;

  localparam int ENV  = 20;
  localparam int GAPM = 400;
  localparam int HOLD = 20000;
  localparam int LAT  = ENV + 3;

  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] dir;
  } ev_t;

  logic       CLK = 0;
  logic       RESET_N = 0;
  logic       IR_IN = 0;
  logic [3:0] DIR;
  logic       PKT_VALID;
  logic       PKT_ERR;
  logic       LINK_OK;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   last_push = 0;
  int   saved;
  int   v5;
  logic prev_valid = 0;
  logic [3:0] exp_dir = 0;
  ev_t  q[$];

  ir_packet_decoder #(
    .ENV_TIMEOUT (ENV),
    .GAP_MAX     (GAPM),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IR_IN     (IR_IN),
    .DIR       (DIR),
    .PKT_VALID (PKT_VALID),
    .PKT_ERR   (PKT_ERR),
    .LINK_OK   (LINK_OK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (!RESET_N) begin
      prev_valid = 0;
    end else begin
      if (prev_valid) check("valid_width", PKT_VALID, 0);
      if (PKT_ERR) check("err_excl", PKT_VALID, 0);
      if (PKT_VALID || PKT_ERR) begin
        if (PKT_VALID) n_valid++;
        if (PKT_ERR) n_err++;
        check("unexpected_event", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("ev_kind", PKT_VALID ? K_VALID : K_ERR, e.kind);
          check("ev_cycle", cyc, e.cyc);
          check("ev_dir", DIR, e.dir);
          if (e.kind == K_VALID) check("ev_link", LINK_OK, 1);
        end
      end
      prev_valid = PKT_VALID;
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic burst(
    input int         n,
    input int         kind,
    input int         lat,
    input logic [3:0] d
  );
    for (int i = 0; i < n; i++) begin
      IR_IN = 1;
      if (i == n - 1 && kind != 0) begin
        last_push = cyc + 1 + lat;
        q.push_back('{kind, last_push, d});
      end
      idle(4);
      IR_IN = 0;
      idle(4);
    end
  endtask

  task automatic packet(
    input int s, input int sl,
    input int r, input int l,
    input int b, input int f,
    input logic [3:0] d
  );
    burst(s, 0, 0, 0);  idle(40);
    burst(sl, 0, 0, 0); idle(40);
    burst(r, 0, 0, 0);  idle(40);
    burst(l, 0, 0, 0);  idle(40);
    burst(b, 0, 0, 0);  idle(40);
    burst(f, K_VALID, LAT, d);
    idle(40);
    exp_dir = d;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: cyc=%0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    idle(5);
    check("rst_dir", DIR, 0);
    check("rst_valid", PKT_VALID, 0);
    check("rst_err", PKT_ERR, 0);
    check("rst_link", LINK_OK, 0);
    RESET_N = 1;
    idle(10);

    packet(191, 47, 47, 22, 22, 47, 4'b1001);
    check("p1_dir", DIR, 4'b1001);
    check("p1_link", LINK_OK, 1);

    burst(191, 0, 0, 0); idle(40);
    burst(30, K_ERR, LAT, exp_dir); idle(60);
    check("sel_dir", DIR, 4'b1001);
    packet(191, 43, 47, 47, 47, 22, 4'b0111);
    check("p2_dir", DIR, 4'b0111);

    burst(191, 0, 0, 0); idle(40);
    burst(47, 0, 0, 0);  idle(40);
    burst(47, 0, 0, 0);  idle(40);
    burst(22, K_ERR, LAT + GAPM + 1, exp_dir);
    idle(500);
    check("gap_dir", DIR, 4'b0111);
    check("gap_errs", n_err, 2);

    packet(187, 51, 43, 26, 26, 51, 4'b1001);
    v5 = last_push;
    check("tol_dir", DIR, 4'b1001);

    saved = n_err;
    burst(196, 0, 0, 0); idle(80);
    check("start196_noerr", n_err, saved);
    check("start196_dir", DIR, 4'b1001);

    while (cyc < v5 + HOLD - 1) @(negedge CLK);
    check("hold_pre_link", LINK_OK, 1);
    check("hold_pre_dir", DIR, 4'b1001);
    @(negedge CLK);
    check("hold_cyc", cyc, v5 + HOLD);
    check("hold_link", LINK_OK, 0);
    check("hold_dir", DIR, 0);
    exp_dir = 0;

    packet(191, 47, 47, 22, 47, 22, 4'b0101);
    check("p4_dir", DIR, 4'b0101);
    saved = n_valid;
    burst(191, 0, 0, 0); idle(40);
    burst(47, 0, 0, 0);  idle(40);
    burst(47, 0, 0, 0);  idle(40);
    burst(22, 0, 0, 0);  idle(40);
    burst(20, 0, 0, 0);
    RESET_N = 0;
    #1;
    check("mid_rst_dir", DIR, 0);
    check("mid_rst_valid", PKT_VALID, 0);
    check("mid_rst_err", PKT_ERR, 0);
    check("mid_rst_link", LINK_OK, 0);
    exp_dir = 0;
    idle(3);
    RESET_N = 1;
    burst(27, 0, 0, 0); idle(40);
    burst(47, 0, 0, 0); idle(80);
    check("post_rst_novalid", n_valid, saved);
    check("post_rst_dir", DIR, 0);

    packet(191, 47, 22, 22, 22, 47, 4'b1000);
    check("p5_dir", DIR, 4'b1000);
    check("q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
